// File: rtl/cycle_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : cycle_sequencer
//  Brief    : T-state / machine-cycle sequencer with RUN/HALT control and a
//             sticky overrun flag for instructions longer than 8 machine cycles.
//  Revision : 1.0  initial release
// ============================================================================
module cycle_sequencer (
    input  logic       i_Clk,
    input  logic       i_Rst_n,
    input  logic       i_Stall,
    input  logic       i_IR_Fetch,
    input  logic       i_Halt_Req,
    input  logic       i_Wake,
    output logic [3:0] o_Cycle_Step,
    output logic [7:0] o_Cycle_Count,
    output logic       o_Active,
    output logic       o_IR_Latch,
    output logic       o_Overrun
);

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    localparam logic [3:0] C_STEP_T1 = 4'b0001;
    localparam logic [7:0] C_CNT_M1  = 8'h01;

    state_t     state_q,   state_d;
    logic [3:0] step_q,    step_d;
    logic [7:0] count_q,   count_d;
    logic       overrun_q, overrun_d;

    logic       w_cycle_end;

    // Machine-cycle boundary: last T-state of the cycle on an edge that advances.
    assign w_cycle_end = step_q[3] & ~i_Stall;

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q   <= ST_RUN;
            step_q    <= C_STEP_T1;
            count_q   <= C_CNT_M1;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            step_q    <= step_d;
            count_q   <= count_d;
            overrun_q <= overrun_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        step_d    = step_q;
        count_d   = count_q;
        overrun_d = overrun_q;

        if (!i_Stall) begin
            step_d = {step_q[2:0], step_q[3]};
        end

        if (w_cycle_end) begin
            case (state_q)
                ST_RUN: begin
                    if (i_IR_Fetch) begin
                        count_d = C_CNT_M1;
                        // Wake is deliberately not sampled here; halt wins at the boundary.
                        if (i_Halt_Req) begin
                            state_d = ST_HALT;
                        end
                    end else if (count_q[7]) begin
                        count_d   = C_CNT_M1;
                        overrun_d = 1'b1;
                    end else begin
                        count_d = {count_q[6:0], 1'b0};
                    end
                end
                ST_HALT: begin
                    count_d = C_CNT_M1;
                    if (i_Wake) begin
                        state_d = ST_RUN;
                    end
                end
                default: begin
                    state_d = ST_RUN;
                    count_d = C_CNT_M1;
                end
            endcase
        end
    end

    assign o_Cycle_Step  = step_q;
    assign o_Cycle_Count = count_q;
    assign o_Active      = (state_q == ST_RUN);
    assign o_Overrun     = overrun_q;
    assign o_IR_Latch    = o_Active & i_IR_Fetch & step_q[3] & ~i_Stall;

endmodule
`default_nettype wire

// File: tb/tb_cycle_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cycle_sequencer
//  Brief    : Directed self-checking bench for cycle_sequencer.
//  Revision : 1.0  initial release
// ============================================================================
module tb_cycle_sequencer;

    logic       clk;
    logic       rst_n;
    logic       stall;
    logic       ir_fetch;
    logic       halt_req;
    logic       wake;
    logic [3:0] step;
    logic [7:0] count;
    logic       active;
    logic       ir_latch;
    logic       overrun;

    int checks = 0;
    int errors = 0;

    cycle_sequencer dut (
        .i_Clk         (clk),
        .i_Rst_n       (rst_n),
        .i_Stall       (stall),
        .i_IR_Fetch    (ir_fetch),
        .i_Halt_Req    (halt_req),
        .i_Wake        (wake),
        .o_Cycle_Step  (step),
        .o_Cycle_Count (count),
        .o_Active      (active),
        .o_IR_Latch    (ir_latch),
        .o_Overrun     (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_all(input string tag, input logic [3:0] es, input logic [7:0] ec,
                           input logic ea, input logic eo);
        chk({tag, "_step"},    {28'd0, step},    {28'd0, es});
        chk({tag, "_count"},   {24'd0, count},   {24'd0, ec});
        chk({tag, "_active"},  {31'd0, active},  {31'd0, ea});
        chk({tag, "_overrun"}, {31'd0, overrun}, {31'd0, eo});
    endtask

    initial begin
        rst_n    = 1'b0;
        stall    = 1'b0;
        ir_fetch = 1'b0;
        halt_req = 1'b0;
        wake     = 1'b0;

        // Reset state
        @(negedge clk);
        chk_all("reset", 4'b0001, 8'h01, 1'b1, 1'b0);
        chk("reset_latch", {31'd0, ir_latch}, 32'd0);
        rst_n = 1'b1;

        // Free-running with no fetch: 8 machine cycles then overrun wrap
        for (int k = 1; k <= 32; k++) begin
            tick();
            chk_all($sformatf("run%0d", k), 4'b0001 << (k % 4), 8'h01 << ((k / 4) % 8),
                    1'b1, (k >= 32));
        end
        // Overrun is sticky
        repeat (4) tick();
        chk("overrun_sticky", {31'd0, overrun}, 32'd1);

        // Fresh reset, then instruction ends in M4
        rst_n = 1'b0;
        #1;
        chk_all("rst2", 4'b0001, 8'h01, 1'b1, 1'b0);
        rst_n = 1'b1;
        repeat (12) tick();
        chk_all("m4_start", 4'b0001, 8'h08, 1'b1, 1'b0);
        ir_fetch = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("latch_t%0d", i), {31'd0, ir_latch}, {31'd0, (i == 3)});
            tick();
        end
        ir_fetch = 1'b0;
        chk_all("after_fetch", 4'b0001, 8'h01, 1'b1, 1'b0);

        // Stall at step 0100 of M2
        repeat (6) tick();
        chk_all("pre_stall", 4'b0100, 8'h02, 1'b1, 1'b0);
        stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_all($sformatf("stall%0d", i), 4'b0100, 8'h02, 1'b1, 1'b0);
        end
        // Stalled end-of-cycle: no latch, no count change
        repeat (1) begin
            stall = 1'b0;
            tick();
            stall = 1'b1;
            ir_fetch = 1'b1;
            #1;
            chk("stall_latch", {31'd0, ir_latch}, 32'd0);
            tick();
            chk_all("stall_eoc", 4'b1000, 8'h02, 1'b1, 1'b0);
            ir_fetch = 1'b0;
            stall = 1'b0;
        end
        tick();
        chk_all("post_stall", 4'b0001, 8'h04, 1'b1, 1'b0);

        // Halt_Req ignored without fetch at end of M3
        halt_req = 1'b1;
        repeat (4) tick();
        chk_all("halt_ignored", 4'b0001, 8'h08, 1'b1, 1'b0);
        halt_req = 1'b0;

        // Halt + wake at the boundary: halt wins
        repeat (3) tick();
        ir_fetch = 1'b1;
        halt_req = 1'b1;
        wake     = 1'b1;
        tick();
        ir_fetch = 1'b0;
        halt_req = 1'b0;
        wake     = 1'b0;
        chk_all("halted", 4'b0001, 8'h01, 1'b0, 1'b0);
        tick();
        chk_all("halt_rot", 4'b0010, 8'h01, 1'b0, 1'b0);
        wake = 1'b1;
        tick();
        wake = 1'b0;
        chk_all("wake_early", 4'b0100, 8'h01, 1'b0, 1'b0);
        tick();
        wake     = 1'b1;
        ir_fetch = 1'b1;
        #1;
        chk("halt_latch", {31'd0, ir_latch}, 32'd0);
        tick();
        wake     = 1'b0;
        ir_fetch = 1'b0;
        chk_all("woken", 4'b0001, 8'h01, 1'b1, 1'b0);

        // Asynchronous reset in M3 step 0100
        repeat (10) tick();
        chk_all("m3_t3", 4'b0100, 8'h04, 1'b1, 1'b0);
        ir_fetch = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk_all("async_rst", 4'b0001, 8'h01, 1'b1, 1'b0);
        chk("async_rst_latch", {31'd0, ir_latch}, 32'd0);
        ir_fetch = 1'b0;
        rst_n = 1'b1;
        tick();
        chk_all("resume", 4'b0010, 8'h01, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
